// File: rtl/tc_register_readout_seq_pkg.sv
// rtl/tc_register_readout_seq_pkg.sv - shared state encoding and index width helper for the readout sequencer
package tc_register_readout_seq_pkg;

  // Sequencer states, 3-bit encoding
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEEK    = 3'd1,
    ST_ASSERT  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_PRESENT = 3'd4,
    ST_FINISH  = 3'd5
  } state_t;

  // Index width for a bank of n registers: max(1, clog2(n))
  function automatic int idx_width(input int n);
    int w;
    w = 1;
    for (int k = 1; k < 32; k++) begin
      if ((1 << w) < n) w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/tc_onehot_dec.sv
// rtl/tc_onehot_dec.sv - index to one-hot decoder with enable, drives the bank load strobes
module tc_onehot_dec #(
  parameter int IDX_W   = 2,
  parameter int NUM_OUT = 4
) (
  input  logic               en,
  input  logic [IDX_W-1:0]   idx,
  output logic [NUM_OUT-1:0] onehot
);

  // Exactly one bit set when enabled and idx is in range, all zero otherwise
  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      onehot[i] = en && (idx == IDX_W'(i));
    end
  end

endmodule

// File: rtl/tc_register_readout_seq.sv
// rtl/tc_register_readout_seq.sv - walks a register bank, captures each word and hands it downstream
module tc_register_readout_seq
  import tc_register_readout_seq_pkg::*;
#(
  parameter int NUM_REGS  = 4,
  parameter int BIT_WIDTH = 8,
  parameter int IDX_W     = idx_width(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_REGS-1:0]  mask,
  output logic                 busy,
  output logic [NUM_REGS-1:0]  load,
  input  logic [BIT_WIDTH-1:0] bus_in,
  output logic [BIT_WIDTH-1:0] out_data,
  output logic [IDX_W-1:0]     out_idx,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 done
);

  // idx carries one extra bit so a full power-of-two bank ends at NUM_REGS instead of wrapping
  localparam logic [IDX_W:0] IDX_END = (IDX_W+1)'(NUM_REGS);
  localparam logic [IDX_W:0] IDX_ONE = (IDX_W+1)'(1);

  state_t              state;
  logic [IDX_W:0]      idx_q;
  logic [NUM_REGS-1:0] mask_q;
  logic [IDX_W-1:0]    idx_lo;
  logic                idx_in_range;
  logic                cur_sel;
  logic                load_en;

  assign idx_lo       = idx_q[IDX_W-1:0];
  assign idx_in_range = (idx_q < IDX_END);
  assign cur_sel      = mask_q[idx_lo];

  // Load is held for the settle cycle and the capture cycle only
  assign load_en = (state == ST_ASSERT) || (state == ST_CAPTURE);

  tc_onehot_dec #(
    .IDX_W   (IDX_W),
    .NUM_OUT (NUM_REGS)
  ) u_load_dec (
    .en     (load_en),
    .idx    (idx_lo),
    .onehot (load)
  );

  // Sweep sequencer with registered handshake and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx_q     <= '0;
      mask_q    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            mask_q <= mask;
            idx_q  <= '0;
            busy   <= 1'b1;
            state  <= ST_SEEK;
          end
        end
        ST_SEEK: begin
          if (!idx_in_range) begin
            done  <= 1'b1;
            state <= ST_FINISH;
          end else if (cur_sel) begin
            state <= ST_ASSERT;
          end else begin
            idx_q <= idx_q + IDX_ONE;
          end
        end
        ST_ASSERT: begin
          state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          out_data  <= bus_in;
          out_idx   <= idx_lo;
          out_valid <= 1'b1;
          state     <= ST_PRESENT;
        end
        ST_PRESENT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            idx_q     <= idx_q + IDX_ONE;
            state     <= ST_SEEK;
          end
        end
        ST_FINISH: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tc_register_readout_seq.sv
// tb/tb_tc_register_readout_seq.sv - directed self-checking bench for the register readout sequencer
module tb_tc_register_readout_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] mask;
  logic       busy;
  logic [3:0] load;
  logic [7:0] bus_in;
  logic [7:0] out_data;
  logic [1:0] out_idx;
  logic       out_valid;
  logic       out_ready;
  logic       done;

  int errors = 0;
  int checks = 0;

  // Results gathered by one sweep
  int         nwords;
  int         w_idx [8];
  int         w_data[8];
  int         done_cnt;
  int         done_cyc;
  int         first_valid_cyc;
  logic [3:0] load_seen;
  logic       busy_after;
  logic       done_after;
  int         seen_done;

  tc_register_readout_seq #(
    .NUM_REGS  (4),
    .BIT_WIDTH (8),
    .IDX_W     (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mask      (mask),
    .busy      (busy),
    .load      (load),
    .bus_in    (bus_in),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register bank model: 0x11,0x22,0x33,0x44 OR-combined through load gating
  always_comb begin
    bus_in = 8'h00;
    if (load[0]) bus_in = bus_in | 8'h11;
    if (load[1]) bus_in = bus_in | 8'h22;
    if (load[2]) bus_in = bus_in | 8'h33;
    if (load[3]) bus_in = bus_in | 8'h44;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Cycle 0 is the cycle start is presented; samples are taken on negedges from cycle 1 on
  task automatic sweep(input logic [3:0] m, input int stall_idx, input int stall_n, input bit pulse);
    int cyc;
    int stalled;
    nwords = 0; done_cnt = 0; done_cyc = -1; first_valid_cyc = -1;
    load_seen = '0; stalled = 0;
    @(negedge clk);
    start = 1'b1; mask = m; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; mask = 4'b0000;
    cyc = 1;
    while (cyc < 80) begin
      check("load_onehot", 32'($onehot0(load)), 32'd1);
      load_seen = load_seen | load;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      start = pulse && (cyc == 2 || cyc == 9 || done);
      if (out_valid && out_idx == stall_idx && stalled < stall_n) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", 32'(out_data), 32'h33);
        check("stall_idx", 32'(out_idx), 32'd2);
        check("stall_load", 32'(load), 32'd0);
        stalled++;
        out_ready = 1'b0;
      end else begin
        out_ready = 1'b1;
      end
      if (out_valid && out_ready && nwords < 8) begin
        w_idx[nwords]  = int'(out_idx);
        w_data[nwords] = int'(out_data);
        nwords++;
      end
      if (done_cyc >= 0 && cyc > done_cyc) break;
      @(negedge clk);
      cyc++;
    end
    start      = 1'b0;
    busy_after = busy;
    done_after = done;
  endtask

  task automatic check_full_sweep(input string pfx, input int exp_done_cyc);
    check({pfx, "_nwords"}, 32'(nwords), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check({pfx, "_word_idx"}, 32'(w_idx[i]), 32'(i));
      check({pfx, "_word_data"}, 32'(w_data[i]), 32'(8'h11 * (i + 1)));
    end
    check({pfx, "_first_valid_cyc"}, 32'(first_valid_cyc), 32'd4);
    check({pfx, "_done_cyc"}, 32'(exp_done_cyc), 32'(done_cyc));
    check({pfx, "_done_cnt"}, 32'(done_cnt), 32'd1);
    check({pfx, "_busy_after"}, 32'(busy_after), 32'd0);
    check({pfx, "_done_after"}, 32'(done_after), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mask = 4'b0000; out_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_load", 32'(load), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_idx", 32'(out_idx), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1) full mask, ready tied high: one word every 4 cycles, done in cycle 18
    sweep(4'b1111, -1, 0, 1'b0);
    check_full_sweep("t1", 18);
    check("t1_load_seen", 32'(load_seen), 32'h0f);

    // 2) sparse mask: only registers 0 and 2, done in cycle 12
    sweep(4'b0101, -1, 0, 1'b0);
    check("t2_nwords", 32'(nwords), 32'd2);
    check("t2_w0_idx", 32'(w_idx[0]), 32'd0);
    check("t2_w0_data", 32'(w_data[0]), 32'h11);
    check("t2_w1_idx", 32'(w_idx[1]), 32'd2);
    check("t2_w1_data", 32'(w_data[1]), 32'h33);
    check("t2_load_seen", 32'(load_seen), 32'h05);
    check("t2_done_cyc", 32'(done_cyc), 32'd12);
    check("t2_done_cnt", 32'(done_cnt), 32'd1);

    // 3) empty mask: no loads, no words, done in cycle NUM_REGS+2
    sweep(4'b0000, -1, 0, 1'b0);
    check("t3_nwords", 32'(nwords), 32'd0);
    check("t3_first_valid", first_valid_cyc, -1);
    check("t3_load_seen", 32'(load_seen), 32'h00);
    check("t3_done_cyc", 32'(done_cyc), 32'd6);
    check("t3_done_cnt", 32'(done_cnt), 32'd1);
    check("t3_busy_after", 32'(busy_after), 32'd0);

    // 4) consumer stalls 5 cycles on word 2: words unchanged, sweep 5 cycles longer
    sweep(4'b1111, 2, 5, 1'b0);
    check_full_sweep("t4", 23);

    // 5) reset during CAPTURE of idx 1 (cycle 7)
    @(negedge clk);
    start = 1'b1; mask = 4'b1111; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; mask = 4'b0000;
    repeat (6) @(negedge clk);
    check("t5_capture_load", 32'(load), 32'h02);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_load", 32'(load), 32'd0);
    check("t5_rst_out_data", 32'(out_data), 32'd0);
    check("t5_rst_out_idx", 32'(out_idx), 32'd0);
    check("t5_rst_out_valid", 32'(out_valid), 32'd0);
    check("t5_rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    seen_done = 0;
    repeat (10) begin
      @(negedge clk);
      if (done || out_valid || busy || load != 4'b0000) seen_done++;
    end
    check("t5_quiet_after_rst", 32'(seen_done), 32'd0);
    sweep(4'b1111, -1, 0, 1'b0);
    check_full_sweep("t5_replay", 18);

    // 6) start pulsed while busy and during FINISH: exactly one sweep
    sweep(4'b1111, -1, 0, 1'b1);
    check_full_sweep("t6", 18);
    seen_done = 0;
    repeat (6) begin
      @(negedge clk);
      if (done || busy || out_valid) seen_done++;
    end
    check("t6_no_second_sweep", 32'(seen_done), 32'd0);

    // start and rst together: rst wins
    @(negedge clk);
    start = 1'b1; mask = 4'b1111; rst = 1'b1;
    @(negedge clk);
    start = 1'b0; rst = 1'b0; mask = 4'b0000;
    check("t7_rst_wins_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("t7_rst_wins_load", 32'(load), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
